// File: rtl/eq_adapt_ctrl.sv
// Equaliser adaptation controller.
// Slices the FFE output (PAM2/PAM4), forms a saturated error against either the
// training reference or the slicer decision, measures windowed MSE and sequences
// IDLE -> TRAIN -> DD_COARSE <-> DD_FINE, selecting the LMS step size per state.
// Ports:
//   clockdsp, soft_reset_n        : clock, asynchronous active-low reset
//   i_en, i_ffe, i_train_sym      : sample valid, equaliser output, training symbol
//   i_start, i_stop, i_pam4       : start pulse, abort, modulation select
//   i_mu_coarse, i_mu_fine        : step sizes; i_mse_thr : lock threshold
//   o_slice, o_error, o_err_valid : registered decision / error / error strobe
//   o_mu, o_adapt_en              : step size and LMS enable for the current state
//   o_mse, o_mse_valid            : windowed mean-square error and its strobe
//   o_converged, o_state          : lock flag, FSM state
module eq_adapt_ctrl #(
    parameter int unsigned OUT_BW    = 9,
    parameter int unsigned ERR_BW    = 8,
    parameter int unsigned MU_BW     = 8,
    parameter int unsigned TRAIN_LEN = 4096,
    parameter int unsigned WIN_LOG2  = 10,
    parameter int unsigned LOSS_WIN  = 4
) (
    input  logic                  clockdsp,
    input  logic                  soft_reset_n,
    input  logic                  i_en,
    input  logic [OUT_BW-1:0]     i_ffe,
    input  logic [OUT_BW-1:0]     i_train_sym,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_pam4,
    input  logic [MU_BW-1:0]      i_mu_coarse,
    input  logic [MU_BW-1:0]      i_mu_fine,
    input  logic [2*ERR_BW-1:0]   i_mse_thr,
    output logic [OUT_BW-1:0]     o_slice,
    output logic [ERR_BW-1:0]     o_error,
    output logic                  o_err_valid,
    output logic [MU_BW-1:0]      o_mu,
    output logic                  o_adapt_en,
    output logic [2*ERR_BW-1:0]   o_mse,
    output logic                  o_mse_valid,
    output logic                  o_converged,
    output logic [2:0]            o_state
);

    localparam int unsigned MSE_BW = 2 * ERR_BW;
    localparam int unsigned ACC_BW = MSE_BW + WIN_LOG2;
    localparam int unsigned EXT_BW = OUT_BW + 1;
    localparam int unsigned TRN_CW = $clog2(TRAIN_LEN + 1);
    localparam int unsigned WIN_CW = WIN_LOG2 + 1;
    localparam int unsigned BAD_CW = $clog2(LOSS_WIN + 1);

    // Outer level 2^(OUT_BW-2), inner level round(outer/3), PAM4 threshold twice the inner level
    localparam int LVL_HI = 2 ** (OUT_BW - 2);
    localparam int LVL_LO = (2 * LVL_HI + 3) / 6;
    localparam int LVL_TH = 2 * LVL_LO;

    localparam logic signed [OUT_BW-1:0] P_HI = OUT_BW'(LVL_HI);
    localparam logic signed [OUT_BW-1:0] N_HI = OUT_BW'(-LVL_HI);
    localparam logic signed [OUT_BW-1:0] P_LO = OUT_BW'(LVL_LO);
    localparam logic signed [OUT_BW-1:0] N_LO = OUT_BW'(-LVL_LO);
    localparam logic signed [OUT_BW-1:0] P_TH = OUT_BW'(LVL_TH);
    localparam logic signed [OUT_BW-1:0] N_TH = OUT_BW'(-LVL_TH);

    localparam logic signed [EXT_BW-1:0] SAT_HI = EXT_BW'(2 ** (ERR_BW - 1) - 1);
    localparam logic signed [EXT_BW-1:0] SAT_LO = EXT_BW'(-(2 ** (ERR_BW - 1)));

    localparam logic [TRN_CW-1:0] TRN_LAST = TRN_CW'(TRAIN_LEN - 1);
    localparam logic [WIN_CW-1:0] WIN_LAST = WIN_CW'(2 ** WIN_LOG2 - 1);
    localparam logic [BAD_CW-1:0] BAD_LAST = BAD_CW'(LOSS_WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRAIN  = 3'd1,
        S_COARSE = 3'd2,
        S_FINE   = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TRN_CW-1:0]   train_cnt_q, train_cnt_d;
    logic [BAD_CW-1:0]   bad_cnt_q, bad_cnt_d;
    logic [WIN_CW-1:0]   win_cnt_q, win_cnt_d;
    logic [ACC_BW-1:0]   acc_q, acc_d;
    logic [OUT_BW-1:0]   slice_q, slice_d;
    logic [ERR_BW-1:0]   error_q, error_d;
    logic                err_valid_q, err_valid_d;
    logic                err_win_q, err_win_d;
    logic [MU_BW-1:0]    mu_q, mu_d;
    logic                adapt_en_q, adapt_en_d;
    logic [MSE_BW-1:0]   mse_q, mse_d;
    logic                mse_valid_q, mse_valid_d;
    logic                converged_q, converged_d;

    logic signed [OUT_BW-1:0] ffe_s;
    logic signed [OUT_BW-1:0] slice_c;
    logic signed [OUT_BW-1:0] ref_c;
    logic signed [EXT_BW-1:0] diff_c;
    logic [ERR_BW-1:0]        err_sat_c;
    logic signed [MSE_BW-1:0] err_ext_c;
    logic [MSE_BW-1:0]        sq_c;
    logic [ACC_BW-1:0]        acc_sum_c;
    logic                     sample_en_c;

    // Slicer, reference select and saturated error
    always_comb begin
        ffe_s = $signed(i_ffe);
        if (!i_pam4) begin
            slice_c = ffe_s[OUT_BW-1] ? N_HI : P_HI;
        end else if (ffe_s >= P_TH) begin
            slice_c = P_HI;
        end else if (!ffe_s[OUT_BW-1]) begin
            slice_c = P_LO;
        end else if (ffe_s > N_TH) begin
            slice_c = N_LO;
        end else begin
            slice_c = N_HI;
        end

        ref_c  = (state_q == S_TRAIN) ? $signed(i_train_sym) : slice_c;
        diff_c = EXT_BW'(ref_c) - EXT_BW'(ffe_s);
        if (diff_c > SAT_HI) begin
            err_sat_c = SAT_HI[ERR_BW-1:0];
        end else if (diff_c < SAT_LO) begin
            err_sat_c = SAT_LO[ERR_BW-1:0];
        end else begin
            err_sat_c = diff_c[ERR_BW-1:0];
        end
    end

    // Next state, counters, MSE window and registered outputs
    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        converged_d = converged_q;
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        mse_d       = mse_q;
        mse_valid_d = 1'b0;
        err_ext_c   = MSE_BW'($signed(error_q));
        sq_c        = err_ext_c * err_ext_c;
        acc_sum_c   = acc_q + ACC_BW'(sq_c);

        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_TRAIN;
            end
            S_TRAIN: begin
                if (i_en) begin
                    if (train_cnt_q == TRN_LAST) state_d = S_COARSE;
                    else train_cnt_d = train_cnt_q + TRN_CW'(1);
                end
            end
            S_COARSE: begin
                if (mse_valid_q && (mse_q < i_mse_thr)) begin
                    state_d     = S_FINE;
                    converged_d = 1'b1;
                end
            end
            S_FINE: begin
                if (mse_valid_q) begin
                    if (mse_q >= i_mse_thr) begin
                        if (bad_cnt_q == BAD_LAST) begin
                            state_d     = S_COARSE;
                            converged_d = 1'b0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BAD_CW'(1);
                        end
                    end else begin
                        bad_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_stop) begin
            state_d     = S_IDLE;
            converged_d = 1'b0;
        end

        sample_en_c = i_en && (state_q != S_IDLE);
        slice_d     = sample_en_c ? slice_c : slice_q;
        error_d     = sample_en_c ? err_sat_c : error_q;
        err_valid_d = sample_en_c;
        // An error captured on a state-change edge belongs to the old state: keep it out of the window
        err_win_d   = sample_en_c && (state_d == state_q);

        if (err_win_q) begin
            if (win_cnt_q == WIN_LAST) begin
                mse_d       = MSE_BW'(acc_sum_c >> WIN_LOG2);
                mse_valid_d = 1'b1;
                acc_d       = '0;
                win_cnt_d   = '0;
            end else begin
                acc_d     = acc_sum_c;
                win_cnt_d = win_cnt_q + WIN_CW'(1);
            end
        end

        if (state_d != state_q) begin
            train_cnt_d = '0;
            bad_cnt_d   = '0;
            win_cnt_d   = '0;
            acc_d       = '0;
            mse_valid_d = 1'b0;
        end

        case (state_d)
            S_IDLE:  mu_d = '0;
            S_FINE:  mu_d = i_mu_fine;
            default: mu_d = i_mu_coarse;
        endcase
        adapt_en_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clockdsp or negedge soft_reset_n) begin
        if (!soft_reset_n) begin
            state_q     <= S_IDLE;
            train_cnt_q <= '0;
            bad_cnt_q   <= '0;
            win_cnt_q   <= '0;
            acc_q       <= '0;
            slice_q     <= '0;
            error_q     <= '0;
            err_valid_q <= 1'b0;
            err_win_q   <= 1'b0;
            mu_q        <= '0;
            adapt_en_q  <= 1'b0;
            mse_q       <= '0;
            mse_valid_q <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            slice_q     <= slice_d;
            error_q     <= error_d;
            err_valid_q <= err_valid_d;
            err_win_q   <= err_win_d;
            mu_q        <= mu_d;
            adapt_en_q  <= adapt_en_d;
            mse_q       <= mse_d;
            mse_valid_q <= mse_valid_d;
            converged_q <= converged_d;
        end
    end

    assign o_slice     = slice_q;
    assign o_error     = error_q;
    assign o_err_valid = err_valid_q;
    assign o_mu        = mu_q;
    assign o_adapt_en  = adapt_en_q;
    assign o_mse       = mse_q;
    assign o_mse_valid = mse_valid_q;
    assign o_converged = converged_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_eq_adapt_ctrl.sv
// Directed bench for eq_adapt_ctrl: table of training-phase slicer/error vectors,
// then hand-written sequences for lock, loss of lock, stop and async reset.
module tb_eq_adapt_ctrl;

    localparam int unsigned OUT_BW    = 9;
    localparam int unsigned ERR_BW    = 8;
    localparam int unsigned MU_BW     = 8;
    localparam int unsigned TRAIN_LEN = 16;
    localparam int unsigned WIN_LOG2  = 2;
    localparam int unsigned LOSS_WIN  = 2;

    localparam int MU_C = 64;
    localparam int MU_F = 4;

    logic                clockdsp = 1'b0;
    logic                soft_reset_n;
    logic                i_en;
    logic [OUT_BW-1:0]   i_ffe;
    logic [OUT_BW-1:0]   i_train_sym;
    logic                i_start;
    logic                i_stop;
    logic                i_pam4;
    logic [MU_BW-1:0]    i_mu_coarse;
    logic [MU_BW-1:0]    i_mu_fine;
    logic [2*ERR_BW-1:0] i_mse_thr;
    logic [OUT_BW-1:0]   o_slice;
    logic [ERR_BW-1:0]   o_error;
    logic                o_err_valid;
    logic [MU_BW-1:0]    o_mu;
    logic                o_adapt_en;
    logic [2*ERR_BW-1:0] o_mse;
    logic                o_mse_valid;
    logic                o_converged;
    logic [2:0]          o_state;

    eq_adapt_ctrl #(
        .OUT_BW(OUT_BW), .ERR_BW(ERR_BW), .MU_BW(MU_BW),
        .TRAIN_LEN(TRAIN_LEN), .WIN_LOG2(WIN_LOG2), .LOSS_WIN(LOSS_WIN)
    ) dut (
        .clockdsp(clockdsp), .soft_reset_n(soft_reset_n),
        .i_en(i_en), .i_ffe(i_ffe), .i_train_sym(i_train_sym),
        .i_start(i_start), .i_stop(i_stop), .i_pam4(i_pam4),
        .i_mu_coarse(i_mu_coarse), .i_mu_fine(i_mu_fine), .i_mse_thr(i_mse_thr),
        .o_slice(o_slice), .o_error(o_error), .o_err_valid(o_err_valid),
        .o_mu(o_mu), .o_adapt_en(o_adapt_en), .o_mse(o_mse),
        .o_mse_valid(o_mse_valid), .o_converged(o_converged), .o_state(o_state)
    );

    always #5 clockdsp = ~clockdsp;

    typedef struct {
        logic pam4;
        int   ffe;
        int   trn;
        int   exp_slice;
        int   exp_err;
        int   exp_state;
    } vec_t;

    vec_t vecs [16];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic pam4, input int ffe, input int trn, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clockdsp);
            i_en        = 1'b1;
            i_pam4      = pam4;
            i_ffe       = OUT_BW'(ffe);
            i_train_sym = OUT_BW'(trn);
        end
        @(negedge clockdsp);
        i_en = 1'b0;
    endtask

    task automatic wait_mse(input string name, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(posedge clockdsp);
            #1;
            if (o_mse_valid) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic next_edge;
        @(posedge clockdsp);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, int'(o_state), 0);
        check({tag, "_slice"}, int'(o_slice), 0);
        check({tag, "_error"}, int'(o_error), 0);
        check({tag, "_errv"},  int'(o_err_valid), 0);
        check({tag, "_mu"},    int'(o_mu), 0);
        check({tag, "_aen"},   int'(o_adapt_en), 0);
        check({tag, "_mse"},   int'(o_mse), 0);
        check({tag, "_msev"},  int'(o_mse_valid), 0);
        check({tag, "_conv"},  int'(o_converged), 0);
    endtask

    initial begin
        int early;
        //          pam4  ffe   trn  slice  err  state
        vecs[0]  = '{1'b0,  100, 128,  128,   28, 1};
        vecs[1]  = '{1'b0, -100,-128, -128,  -28, 1};
        vecs[2]  = '{1'b0,    0, 128,  128,  127, 1};
        vecs[3]  = '{1'b0,   -1,-128, -128, -127, 1};
        vecs[4]  = '{1'b0, -255,   0, -128,  127, 1};
        vecs[5]  = '{1'b0,  255,   0,  128, -128, 1};
        vecs[6]  = '{1'b0, -256, 128, -128,  127, 1};
        vecs[7]  = '{1'b1,  127,   0,  128, -127, 1};
        vecs[8]  = '{1'b1,   86,   0,  128,  -86, 1};
        vecs[9]  = '{1'b1,   85,   0,   43,  -85, 1};
        vecs[10] = '{1'b1,    0,   0,   43,    0, 1};
        vecs[11] = '{1'b1,   -1,   0,  -43,    1, 1};
        vecs[12] = '{1'b1,  -85,   0,  -43,   85, 1};
        vecs[13] = '{1'b1,  -86,   0, -128,   86, 1};
        vecs[14] = '{1'b1, -128,   0, -128,  127, 1};
        vecs[15] = '{1'b0,  124, 128,  128,    4, 2};

        soft_reset_n = 1'b0;
        i_en = 1'b0; i_ffe = '0; i_train_sym = '0;
        i_start = 1'b0; i_stop = 1'b0; i_pam4 = 1'b0;
        i_mu_coarse = MU_BW'(MU_C); i_mu_fine = MU_BW'(MU_F);
        i_mse_thr = 16'd17;

        #22;
        check_zero("rst");
        @(negedge clockdsp);
        soft_reset_n = 1'b1;

        // Samples are ignored while idle
        @(negedge clockdsp);
        i_en = 1'b1; i_ffe = OUT_BW'(100);
        next_edge;
        check("idle_errv", int'(o_err_valid), 0);
        check("idle_slice", int'(o_slice), 0);
        i_en = 1'b0;

        // Simultaneous start and stop: stop wins
        @(negedge clockdsp);
        i_start = 1'b1; i_stop = 1'b1;
        next_edge;
        i_start = 1'b0; i_stop = 1'b0;
        check("startstop_state", int'(o_state), 0);
        check("startstop_aen", int'(o_adapt_en), 0);

        @(negedge clockdsp);
        i_start = 1'b1;
        next_edge;
        i_start = 1'b0;
        check("start_state", int'(o_state), 1);
        check("start_mu", int'(o_mu), MU_C);
        check("start_aen", int'(o_adapt_en), 1);

        // Training vectors, i_en on every other cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clockdsp);
            i_en        = 1'b1;
            i_pam4      = vecs[i].pam4;
            i_ffe       = OUT_BW'(vecs[i].ffe);
            i_train_sym = OUT_BW'(vecs[i].trn);
            next_edge;
            check($sformatf("slice[%0d]", i), $signed(o_slice), vecs[i].exp_slice);
            check($sformatf("error[%0d]", i), $signed(o_error), vecs[i].exp_err);
            check($sformatf("errv[%0d]", i), int'(o_err_valid), 1);
            check($sformatf("state[%0d]", i), int'(o_state), vecs[i].exp_state);
            @(negedge clockdsp);
            i_en = 1'b0;
            next_edge;
            check($sformatf("errv_off[%0d]", i), int'(o_err_valid), 0);
            check($sformatf("err_hold[%0d]", i), $signed(o_error), vecs[i].exp_err);
        end
        check("coarse_mu", int'(o_mu), MU_C);
        check("coarse_conv", int'(o_converged), 0);

        // Decision-directed error beyond the outer level, window too noisy to lock
        send(1'b0, -200, 0, 4);
        check("dd_error", $signed(o_error), 72);
        check("dd_slice", $signed(o_slice), -128);
        wait_mse("mse_bad_seen", 10);
        check("mse_bad", int'(o_mse), 5184);
        next_edge;
        check("nolock_state", int'(o_state), 2);

        // Constant error 4 -> mse 16 < 17: lock
        send(1'b0, 124, 0, 4);
        wait_mse("mse_lock_seen", 10);
        check("mse_lock", int'(o_mse), 16);
        next_edge;
        check("lock_state", int'(o_state), 3);
        check("lock_conv", int'(o_converged), 1);
        check("lock_mu", int'(o_mu), MU_F);

        // Bad, good, bad: good window clears the bad count
        send(1'b0, 120, 0, 4);
        wait_mse("mse_b1_seen", 10);
        check("mse_b1", int'(o_mse), 64);
        next_edge;
        check("b1_state", int'(o_state), 3);
        send(1'b0, 124, 0, 4);
        wait_mse("mse_g_seen", 10);
        next_edge;
        check("g_state", int'(o_state), 3);
        send(1'b0, 120, 0, 4);
        wait_mse("mse_b2_seen", 10);
        next_edge;
        check("b2_state", int'(o_state), 3);

        // Second consecutive bad window -> loss of lock
        send(1'b0, 120, 0, 4);
        wait_mse("mse_b3_seen", 10);
        check("mse_b3", int'(o_mse), 64);
        next_edge;
        check("loss_state", int'(o_state), 2);
        check("loss_conv", int'(o_converged), 0);
        check("loss_mu", int'(o_mu), MU_C);

        // Relock, then abort from DD_FINE
        send(1'b0, 124, 0, 4);
        wait_mse("mse_relock_seen", 10);
        next_edge;
        check("relock_state", int'(o_state), 3);
        @(negedge clockdsp);
        i_stop = 1'b1;
        next_edge;
        i_stop = 1'b0;
        check("stop_state", int'(o_state), 0);
        check("stop_mu", int'(o_mu), 0);
        check("stop_aen", int'(o_adapt_en), 0);
        check("stop_conv", int'(o_converged), 0);

        // Async reset mid-window discards the partial window
        @(negedge clockdsp);
        i_start = 1'b1;
        next_edge;
        i_start = 1'b0;
        check("rs_start_state", int'(o_state), 1);
        send(1'b0, 0, 16, 2);
        @(posedge clockdsp);
        #3;
        soft_reset_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clockdsp);
        soft_reset_n = 1'b1;
        @(negedge clockdsp);
        i_start = 1'b1;
        next_edge;
        i_start = 1'b0;
        check("rs2_state", int'(o_state), 1);
        send(1'b0, 0, 8, 3);
        early = 0;
        for (int c = 0; c < 6; c++) begin
            next_edge;
            if (o_mse_valid) early++;
        end
        check("rs_no_partial", early, 0);
        send(1'b0, 0, 8, 1);
        wait_mse("rs_mse_seen", 10);
        check("rs_mse", int'(o_mse), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/eq_adapt_ctrl.md
EQ_ADAPT_CTRL -- requirements
Module: eq_adapt_ctrl

Interface
REQ-001 SHALL have parameter OUT_BW, default 9, meaning FFE output width, format S(OUT_BW,OUT_BW-2).
REQ-002 SHALL have parameter ERR_BW, default 8, meaning error width, format S(ERR_BW,ERR_BW-1).
REQ-003 SHALL have parameter MU_BW, default 8, meaning step-size width.
REQ-004 SHALL have parameter TRAIN_LEN, default 4096, meaning enabled samples spent in TRAIN (≥1).
REQ-005 SHALL have parameter WIN_LOG2, default 10, meaning log2 of the MSE window in errors.
REQ-006 SHALL have parameter LOSS_WIN, default 4, meaning consecutive bad windows that trigger loss of lock (≥1).
REQ-007 SHALL have ports: clockdsp in 1 (sole clock); soft_reset_n in 1 (reset, asynchronous, active-low).
REQ-008 SHALL have ports: i_en in 1 (sample valid); i_ffe in OUT_BW (equaliser output); i_train_sym in OUT_BW (training reference).
REQ-009 SHALL have ports: i_start in 1 (start pulse); i_stop in 1 (abort); i_pam4 in 1 (0=PAM2, 1=PAM4).
REQ-010 SHALL have ports: i_mu_coarse in MU_BW; i_mu_fine in MU_BW; i_mse_thr in 2*ERR_BW (lock threshold).
REQ-011 SHALL have ports: o_slice out OUT_BW; o_error out ERR_BW; o_err_valid out 1; o_mu out MU_BW; o_adapt_en out 1 (LMS enable).
REQ-012 SHALL have ports: o_mse out 2*ERR_BW; o_mse_valid out 1; o_converged out 1; o_state out 3.

Function
REQ-013 Slicer, PAM2 (OUT_BW=9 values): i_ffe≥0 -> +128, else -128.
REQ-014 Slicer, PAM4: y≥86 -> +128; 0≤y<86 -> +43; -86<y<0 -> -43; y≤-86 -> -128; levels scale with OUT_BW as ±2^(OUT_BW-2) and ±round(2^(OUT_BW-2)/3).
REQ-015 Reference = i_train_sym in TRAIN, slicer decision in other states.
REQ-016 Error = reference - i_ffe, computed in OUT_BW+1 bits, saturated to ERR_BW signed (no wrap).
REQ-017 o_slice, o_error registered on each i_en=1 cycle when state≠IDLE; o_err_valid=1 exactly one cycle later, 0 otherwise; outputs hold between samples.
REQ-018 FSM encoding on o_state: IDLE=0, TRAIN=1, DD_COARSE=2, DD_FINE=3.
REQ-019 IDLE -> TRAIN on i_start=1; i_start ignored in any other state.
REQ-020 TRAIN -> DD_COARSE on the edge registering the TRAIN_LEN-th enabled sample.
REQ-021 DD_COARSE -> DD_FINE on the edge following o_mse_valid=1 with o_mse<i_mse_thr; o_converged set on that same edge.
REQ-022 In DD_FINE, each window with o_mse≥i_mse_thr increments a bad counter, a good window clears it; at LOSS_WIN -> DD_COARSE, o_converged cleared, counter cleared.
REQ-023 i_stop=1 -> IDLE on next edge from any state, clears o_converged; i_stop wins over simultaneous i_start.
REQ-024 o_mu = 0 in IDLE, i_mu_coarse in TRAIN/DD_COARSE, i_mu_fine in DD_FINE, registered; o_adapt_en = 1 in all states except IDLE.
REQ-025 MSE: accumulate o_error² (unsigned, 2*ERR_BW+WIN_LOG2 bits, no overflow possible) on each o_err_valid; after 2^WIN_LOG2 errors, o_mse = acc>>WIN_LOG2, o_mse_valid pulses 1 cycle, accumulator restarts.
REQ-026 Window counter and accumulator clear on every state change; no partial window reported.
REQ-027 i_en=0 freezes sample, TRAIN and window counters.

Reset
REQ-028 soft_reset_n=0 asynchronously forces: state IDLE, all counters/accumulator 0, o_slice, o_error, o_mu, o_mse = 0, o_err_valid, o_mse_valid, o_adapt_en, o_converged = 0.
REQ-029 Reset mid-adaptation discards the partial window; first edge after release is in IDLE.

Verification
REQ-030 PAM2, i_ffe=+100 in TRAIN, i_train_sym=+128 -> o_error=+28; i_ffe=-200 (out of ±1 range) in DD -> error=+72; reference-minus-output of ±255 saturates to ±127/-128.
REQ-031 PAM4 sweep i_ffe∈{127,86,85,0,-1,-85,-86,-128} -> o_slice {128,128,43,43,-43,-43,-128,-128}.
REQ-032 i_start, TRAIN_LEN=16, i_en every other cycle -> DD_COARSE after 16th enabled sample; o_mu switches coarse->fine only on lock.
REQ-033 WIN_LOG2=2, constant error 4 -> o_mse=16; thr=17 -> DD_FINE, o_converged=1; then error 8 for LOSS_WIN windows -> DD_COARSE, o_converged=0.
REQ-034 i_start and i_stop same cycle in IDLE -> stays IDLE; i_stop in DD_FINE -> IDLE, o_mu=0, o_adapt_en=0.
REQ-035 soft_reset_n pulled low between clock edges mid-window -> outputs zero immediately; after release, fresh i_start yields first o_mse_valid only after full window.
